beep_gen: RTL



---
 rtl/beep_pkg.sv | 21 ++
 rtl/beep_gen_tone_div.sv | 50 +++++
 rtl/beep_gen.sv | 133 +++++++++++++
 3 files changed

// File: rtl/beep_pkg.sv
`default_nettype none
// beep_pkg: state encoding and counter-width helpers shared by beep_gen and tone_div.
package beep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  // A counter that must hold values 0..n-1 needs at least one bit even when n <= 1.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/beep_gen_tone_div.sv
`default_nettype none
// tone_div: square-wave divider; restarts high on clr and toggles every TONE_DIV enabled cycles.
module tone_div
  import beep_pkg::*;
#(
  parameter int TONE_DIV = 12500
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic en,
  input  logic clr,
  output logic tone
);

  localparam int            TW    = cnt_w(TONE_DIV);
  localparam logic [TW-1:0] TLAST = TW'(TONE_DIV - 1);

  logic [TW-1:0] cnt;
  logic [TW-1:0] cnt_n;
  logic          tone_q;

  // tone is the value for the coming cycle, so the parent can register it on the same edge.
  always_comb begin
    cnt_n = cnt;
    tone  = tone_q;
    if (clr) begin
      cnt_n = '0;
      tone  = 1'b1;
    end else if (en) begin
      if (cnt == TLAST) begin
        cnt_n = '0;
        tone  = ~tone_q;
      end else begin
        cnt_n = cnt + TW'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt    <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt    <= cnt_n;
      tone_q <= tone;
    end
  end

endmodule
`default_nettype wire

// File: rtl/beep_gen.sv
`default_nettype none
// beep_gen: plays N beeps of a square-wave tone per trigger, with one queued request.
module beep_gen
  import beep_pkg::*;
#(
  parameter int TONE_DIV = 12500,
  parameter int ON_CYC   = 5000000,
  parameter int OFF_CYC  = 5000000,
  parameter int NUM_W    = 3
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             trig,
  input  logic [NUM_W-1:0] beep_num,
  input  logic             mute,
  output logic             buzzer,
  output logic             busy,
  output logic             done,
  output logic             drop
);

  localparam int               PW       = cnt_w(max_int(ON_CYC, OFF_CYC));
  localparam logic [PW-1:0]    ON_LAST  = PW'(ON_CYC - 1);
  localparam logic [PW-1:0]    OFF_LAST = PW'(OFF_CYC - 1);
  localparam logic [NUM_W-1:0] REM_ONE  = NUM_W'(1);

  function automatic logic [NUM_W-1:0] fix_num(input logic [NUM_W-1:0] n);
    return (n == '0) ? REM_ONE : n;
  endfunction

  state_t           state, state_n;
  logic [NUM_W-1:0] rem, rem_n;
  logic [NUM_W-1:0] pend_num, pend_num_n;
  logic [PW-1:0]    phase_cnt, phase_n;
  logic             pending, pending_n;
  logic             done_n, drop_n;
  logic             tone, tone_en, tone_clr;

  always_comb begin
    state_n    = state;
    rem_n      = rem;
    pend_num_n = pend_num;
    phase_n    = phase_cnt;
    pending_n  = pending;
    done_n     = 1'b0;
    drop_n     = 1'b0;
    case (state)
      IDLE: begin
        if (trig) begin
          state_n = ON;
          rem_n   = fix_num(beep_num);
          phase_n = '0;
        end
      end
      ON: begin
        if (phase_cnt == ON_LAST) begin
          state_n = OFF;
          phase_n = '0;
        end else begin
          phase_n = phase_cnt + PW'(1);
        end
      end
      OFF: begin
        if (phase_cnt == OFF_LAST) begin
          phase_n = '0;
          if (rem != REM_ONE) begin
            rem_n   = rem - REM_ONE;
            state_n = ON;
          end else begin
            done_n = 1'b1;
            if (pending) begin
              state_n   = ON;
              rem_n     = fix_num(pend_num);
              pending_n = 1'b0;
            end else begin
              state_n = IDLE;
            end
          end
        end else begin
          phase_n = phase_cnt + PW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    // Checked against pending_n so a slot freed on this edge can take the new request.
    if (trig && (state != IDLE)) begin
      if (!pending_n) begin
        pending_n  = 1'b1;
        pend_num_n = beep_num;
      end else begin
        drop_n = 1'b1;
      end
    end
  end

  assign tone_en  = (state_n == ON);
  assign tone_clr = tone_en && (state != ON);
  assign busy     = (state != IDLE);

  tone_div #(
    .TONE_DIV(TONE_DIV)
  ) u_tone_div (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .en     (tone_en),
    .clr    (tone_clr),
    .tone   (tone)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      rem       <= '0;
      pend_num  <= '0;
      phase_cnt <= '0;
      pending   <= 1'b0;
      done      <= 1'b0;
      drop      <= 1'b0;
      buzzer    <= 1'b0;
    end else begin
      state     <= state_n;
      rem       <= rem_n;
      pend_num  <= pend_num_n;
      phase_cnt <= phase_n;
      pending   <= pending_n;
      done      <= done_n;
      drop      <= drop_n;
      buzzer    <= tone_en && tone && !mute;
    end
  end

endmodule
`default_nettype wire
